// File: rtl/virtio_available_ring_monitor_mq_if.sv
// Request stream carried between the virtqueue scheduler, the credit monitor and the ring reader.
interface virtio_available_ring_monitor_mq_if #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned ID_WIDTH    = 4,
   parameter int unsigned QUEUE_WIDTH = 2
) ();
   logic                   tvalid;
   logic                   tready;
   logic [DATA_WIDTH-1:0]  tdata;
   logic [ID_WIDTH-1:0]    tid;
   logic [QUEUE_WIDTH-1:0] tdest;
   logic                   tlast;

   modport master (output tvalid, tdata, tid, tdest, tlast, input tready);
   modport slave  (input tvalid, tdata, tid, tdest, tlast, output tready);
endinterface

// File: rtl/virtio_available_ring_monitor_mq.sv
// Per-queue descriptor-index buffer credit monitor: admits read-ring requests only when their
// reservation fits, and returns credit by tapping the buffer's read side.
module virtio_available_ring_monitor_mq #(
   parameter int unsigned NUM_QUEUES             = 4,
   parameter int unsigned CAPACITY               = 16,
   parameter int unsigned MAX_DESCRIPTOR_INDEXES = 4,
   parameter int unsigned DATA_WIDTH             = 64,
   parameter int unsigned ID_WIDTH               = 4,
   parameter int unsigned REQUEST_READ_RING      = 1,
   parameter int unsigned QUEUE_WIDTH            = (NUM_QUEUES >= 2) ? $clog2(NUM_QUEUES) : 1,
   parameter int unsigned CAPACITY_WIDTH         = $clog2(CAPACITY) + 1
) (
   input  logic                                 aclk,
   input  logic                                 areset_n,
   virtio_available_ring_monitor_mq_if.slave    rx,
   virtio_available_ring_monitor_mq_if.master   tx,
   input  logic                                 monitor_tvalid,
   input  logic                                 monitor_tready,
   input  logic [QUEUE_WIDTH-1:0]               monitor_tdest,
   input  logic                                 error_clear,
   output logic [NUM_QUEUES*CAPACITY_WIDTH-1:0] level,
   output logic [NUM_QUEUES-1:0]                full,
   output logic [NUM_QUEUES-1:0]                error_underflow,
   output logic [NUM_QUEUES-1:0]                error_oversize
);
   localparam int unsigned INDEX_SHIFT = $clog2(MAX_DESCRIPTOR_INDEXES);
   localparam int unsigned SUM_WIDTH   = CAPACITY_WIDTH + 1;

   typedef logic [CAPACITY_WIDTH-1:0] level_t;

   logic [16:0]            add_wide;
   level_t                 add;
   level_t                 level_sel;
   logic                   read_ring;
   logic                   oversize;
   logic                   blocked;
   logic                   ready;
   logic                   write;
   logic [SUM_WIDTH-1:0]   sum;

   level_t                 level_q [NUM_QUEUES];
   level_t                 level_d [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]  underflow_q, underflow_d;
   logic [NUM_QUEUES-1:0]  oversize_q, oversize_d;
   logic                   rd_q;
   logic [QUEUE_WIDTH-1:0] rd_queue_q;

   logic                   tx_valid_q;
   logic [DATA_WIDTH-1:0]  tx_data_q;
   logic [ID_WIDTH-1:0]    tx_id_q;
   logic [QUEUE_WIDTH-1:0] tx_dest_q;
   logic                   tx_last_q;

   // Admission: reservation is computed wide so huge counts cannot wrap into a small add.
   always_comb begin
      add_wide  = (17'(rx.tdata[15:0]) + 17'(MAX_DESCRIPTOR_INDEXES - 1)) >> INDEX_SHIFT;
      add       = add_wide[CAPACITY_WIDTH-1:0];
      read_ring = rx.tid == ID_WIDTH'(REQUEST_READ_RING);
      oversize  = read_ring && (add_wide > 17'(CAPACITY));
      level_sel = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         if (rx.tdest == QUEUE_WIDTH'(q)) level_sel = level_q[q];
      end
      blocked   = read_ring && !oversize &&
                  ((SUM_WIDTH'(level_sel) + SUM_WIDTH'(add)) > SUM_WIDTH'(CAPACITY));
      ready     = tx.tready && !(rx.tvalid && blocked);
      write     = rx.tvalid && ready && read_ring && !oversize;
      rx.tready = ready;
   end

   // Per-queue counters; a read with nothing to return saturates at zero and flags underflow.
   always_comb begin
      sum         = '0;
      underflow_d = underflow_q;
      oversize_d  = oversize_q;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         sum = {1'b0, level_q[q]};
         if (write && rx.tdest == QUEUE_WIDTH'(q)) sum = sum + SUM_WIDTH'(add);
         if (error_clear) begin
            underflow_d[q] = 1'b0;
            oversize_d[q]  = 1'b0;
         end
         if (rd_q && rd_queue_q == QUEUE_WIDTH'(q)) begin
            if (sum == '0) underflow_d[q] = 1'b1;
            else sum = sum - SUM_WIDTH'(1);
         end
         if (rx.tvalid && ready && oversize && rx.tdest == QUEUE_WIDTH'(q)) begin
            oversize_d[q] = 1'b1;
         end
         level_d[q] = sum[CAPACITY_WIDTH-1:0];
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         tx_valid_q  <= 1'b0;
         rd_q        <= 1'b0;
         rd_queue_q  <= '0;
         underflow_q <= '0;
         oversize_q  <= '0;
         for (int q = 0; q < NUM_QUEUES; q++) level_q[q] <= '0;
      end else begin
         if (tx.tready) tx_valid_q <= rx.tvalid && !blocked;
         rd_q        <= monitor_tvalid && monitor_tready;
         rd_queue_q  <= monitor_tdest;
         underflow_q <= underflow_d;
         oversize_q  <= oversize_d;
         for (int q = 0; q < NUM_QUEUES; q++) level_q[q] <= level_d[q];
      end
   end

   // Payload flops carry no reset; they are qualified by tx_valid_q.
   always_ff @(posedge aclk) begin
      if (tx.tready) begin
         tx_data_q <= rx.tdata;
         tx_id_q   <= rx.tid;
         tx_dest_q <= rx.tdest;
         tx_last_q <= rx.tlast;
      end
   end

   always_comb begin
      tx.tvalid = tx_valid_q;
      tx.tdata  = tx_data_q;
      tx.tid    = tx_id_q;
      tx.tdest  = tx_dest_q;
      tx.tlast  = tx_last_q;
      level     = '0;
      full      = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         level[q*CAPACITY_WIDTH +: CAPACITY_WIDTH] = level_q[q];
         full[q] = level_q[q] == CAPACITY_WIDTH'(CAPACITY);
      end
      error_underflow = underflow_q;
      error_oversize  = oversize_q;
   end
endmodule

// File: tb/tb_virtio_available_ring_monitor_mq.sv
// Bench for the multi-queue available-ring credit monitor: per-cycle vector table plus a tx
// scoreboard and a mid-transfer asynchronous reset sequence.
module tb_virtio_available_ring_monitor_mq;
   localparam int unsigned NQ = 4;
   localparam int unsigned CW = 5;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;
   localparam int unsigned QW = 2;
   localparam int RR = 1;
   localparam int OT = 2;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   always #5 aclk = ~aclk;

   virtio_available_ring_monitor_mq_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .QUEUE_WIDTH(QW)) rx_if ();
   virtio_available_ring_monitor_mq_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .QUEUE_WIDTH(QW)) tx_if ();

   logic          monitor_tvalid, monitor_tready, error_clear;
   logic [QW-1:0] monitor_tdest;
   logic [NQ*CW-1:0] level;
   logic [NQ-1:0] full, error_underflow, error_oversize;

   virtio_available_ring_monitor_mq #(
      .NUM_QUEUES(NQ), .CAPACITY(16), .MAX_DESCRIPTOR_INDEXES(4), .DATA_WIDTH(DW),
      .ID_WIDTH(IW), .REQUEST_READ_RING(RR)
   ) dut (
      .aclk(aclk), .areset_n(areset_n), .rx(rx_if), .tx(tx_if),
      .monitor_tvalid(monitor_tvalid), .monitor_tready(monitor_tready),
      .monitor_tdest(monitor_tdest), .error_clear(error_clear), .level(level), .full(full),
      .error_underflow(error_underflow), .error_oversize(error_oversize)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
      logic [QW-1:0] dest;
      logic          last;
   } beat_t;

   typedef struct {
      logic vld; logic [15:0] cnt; logic [IW-1:0] tid; logic [QW-1:0] dest;
      logic mon; logic [QW-1:0] mdest; logic clr; logic txr; logic rdy;
      logic [NQ*CW-1:0] lv; logic [NQ-1:0] full; logic [NQ-1:0] uf; logic [NQ-1:0] ov;
   } vec_t;

   beat_t expq[$];
   vec_t  vecs[$];
   beat_t mon_act, mon_exp;
   int    n_checks = 0;
   int    n_fail = 0;

   function automatic logic [DW-1:0] pat(input logic [15:0] c);
      return {16'hBEEF, c ^ 16'h5A5A, 16'hCAFE, c};
   endfunction

   function automatic vec_t v(input int vld, cnt, tid, dest, mon, mdest, clr, txr, rdy,
                              l0, l1, l2, l3, fl, uf, ov);
      vec_t r;
      r.vld = 1'(vld); r.cnt = 16'(cnt); r.tid = IW'(tid); r.dest = QW'(dest);
      r.mon = 1'(mon); r.mdest = QW'(mdest); r.clr = 1'(clr); r.txr = 1'(txr); r.rdy = 1'(rdy);
      r.lv = {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
      r.full = NQ'(fl); r.uf = NQ'(uf); r.ov = NQ'(ov);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // tx scoreboard: one expected beat per accepted request, consumed on each tx transfer.
   always @(negedge aclk) begin
      if (areset_n && tx_if.tvalid && tx_if.tready) begin
         mon_act = '{data: tx_if.tdata, id: tx_if.tid, dest: tx_if.tdest, last: tx_if.tlast};
         n_checks++;
         if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got %0h, required no beat", mon_act);
         end else begin
            mon_exp = expq.pop_front();
            if (mon_act !== mon_exp) begin
               n_fail++;
               $display("FAIL tx_beat: got %0h, required %0h", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      //            vld cnt tid dst mon md clr txr rdy l0 l1 l2 l3 full    uf      ov
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1,  5, RR, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 0, 2,  0, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1, 16, RR, 2, 0, 0, 0, 1, 1, 0, 2,  0, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1, 16, RR, 2, 0, 0, 0, 1, 1, 0, 2,  4, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1, 16, RR, 2, 0, 0, 0, 1, 1, 0, 2,  8, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1, 12, RR, 2, 0, 0, 0, 1, 1, 0, 2, 12, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1,  8, RR, 2, 0, 0, 0, 1, 0, 0, 2, 15, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1,  8, RR, 2, 1, 2, 0, 1, 0, 0, 2, 15, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1,  8, RR, 2, 0, 0, 0, 1, 0, 0, 2, 15, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1,  8, RR, 2, 0, 0, 0, 1, 1, 0, 2, 14, 0, 'b0000, 'b0000, 'b0000));
      vecs.push_back(v(1, 20, RR, 0, 0, 0, 0, 1, 1, 0, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 1, 0, 0, 1, 1, 5, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(1,  9, RR, 0, 0, 0, 0, 1, 1, 5, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 1, 3, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b1000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b1000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 1, 1, 1, 7, 2, 16, 0, 'b0100, 'b1000, 'b0000));
      vecs.push_back(v(1,100, RR, 0, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b0000, 'b0000));
      vecs.push_back(v(1,  8, OT, 2, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(1,  4, RR, 1, 0, 0, 0, 0, 0, 7, 2, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(1,  4, RR, 1, 0, 0, 0, 0, 0, 7, 2, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(1,  4, RR, 1, 0, 0, 0, 0, 0, 7, 2, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(1,  4, RR, 1, 0, 0, 0, 1, 1, 7, 2, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 3, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(0,  0, OT, 0, 1, 3, 0, 1, 1, 7, 3, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 1, 1, 1, 7, 3, 16, 0, 'b0100, 'b0000, 'b0001));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 3, 16, 0, 'b0100, 'b1000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 1, 1, 1, 7, 3, 16, 0, 'b0100, 'b1000, 'b0000));
      vecs.push_back(v(0,  0, OT, 0, 0, 0, 0, 1, 1, 7, 3, 16, 0, 'b0100, 'b0000, 'b0000));

      rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tid = '0; rx_if.tdest = '0; rx_if.tlast = 1'b0;
      tx_if.tready = 1'b1;
      monitor_tvalid = 1'b1; monitor_tready = 1'b0; monitor_tdest = '0; error_clear = 1'b0;
      repeat (3) @(posedge aclk);
      #1 areset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge aclk);
         #1;
         rx_if.tvalid   = vecs[i].vld;
         rx_if.tdata    = pat(vecs[i].cnt);
         rx_if.tid      = vecs[i].tid;
         rx_if.tdest    = vecs[i].dest;
         rx_if.tlast    = vecs[i].cnt[0];
         monitor_tready = vecs[i].mon;
         monitor_tdest  = vecs[i].mdest;
         error_clear    = vecs[i].clr;
         tx_if.tready   = vecs[i].txr;
         @(negedge aclk);
         chk($sformatf("rx_tready row %0d", i), 64'(rx_if.tready), 64'(vecs[i].rdy));
         chk($sformatf("level row %0d", i), 64'(level), 64'(vecs[i].lv));
         chk($sformatf("full row %0d", i), 64'(full), 64'(vecs[i].full));
         chk($sformatf("error_underflow row %0d", i), 64'(error_underflow), 64'(vecs[i].uf));
         chk($sformatf("error_oversize row %0d", i), 64'(error_oversize), 64'(vecs[i].ov));
         if (vecs[i].vld && vecs[i].rdy) begin
            expq.push_back('{data: pat(vecs[i].cnt), id: vecs[i].tid, dest: vecs[i].dest,
                             last: vecs[i].cnt[0]});
         end
      end

      // Asynchronous reset while a forwarded beat is still on tx.
      @(posedge aclk);
      #1;
      rx_if.tvalid = 1'b1; rx_if.tdata = pat(16'd4); rx_if.tid = IW'(RR); rx_if.tdest = 2'd1;
      rx_if.tlast = 1'b0; monitor_tready = 1'b0; error_clear = 1'b0; tx_if.tready = 1'b1;
      @(negedge aclk);
      chk("rx_tready before reset", 64'(rx_if.tready), 64'd1);
      @(posedge aclk);
      #1;
      rx_if.tvalid = 1'b0;
      chk("tx_tvalid before reset", 64'(tx_if.tvalid), 64'd1);
      chk("level before reset", 64'(level), 64'({5'd0, 5'd16, 5'd4, 5'd7}));
      areset_n = 1'b0;
      #1;
      chk("tx_tvalid in reset", 64'(tx_if.tvalid), 64'd0);
      chk("level in reset", 64'(level), 64'd0);
      chk("full in reset", 64'(full), 64'd0);
      chk("errors in reset", 64'({error_underflow, error_oversize}), 64'd0);
      @(posedge aclk);
      #1 areset_n = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      chk("tx_tvalid after reset", 64'(tx_if.tvalid), 64'd0);
      chk("scoreboard drained", 64'(expq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/virtio_available_ring_monitor_mq.md
Name: virtio_available_ring_monitor_mq

Overview:
Multi-queue successor of the available-ring credit monitor. It sits between the virtqueue request scheduler (rx) and the available-ring reader (tx). It keeps a separate descriptor-index buffer occupancy counter for each queue. A read-ring request is admitted only when its reservation fits exactly into that queue's buffer, and the counter is returned by observing the monitor stream of the descriptor-index buffer. It adds per-queue status, exact-fit admission, and sticky underflow and oversize error detection.

Parameters:
NUM_QUEUES, 4, number of virtqueues tracked (power of 2, >=1)
CAPACITY, 16, per-queue buffer depth in transactions (power of 2, >=2)
MAX_DESCRIPTOR_INDEXES, 4, descriptor indexes per buffer transaction (power of 2)
DATA_WIDTH, 64, rx/tx tdata width (>=16)
ID_WIDTH, 4, tid width, which carries the request_type_t code
QUEUE_WIDTH, (NUM_QUEUES>=2)?$clog2(NUM_QUEUES):1, derived queue index width
CAPACITY_WIDTH, $clog2(CAPACITY)+1, derived counter width

Ports:
aclk  input  1  clock
areset_n  input  1  asynchronous active-low reset
rx_tvalid/rx_tready  input/output  1/1  request handshake
rx_tdata  input  DATA_WIDTH  request; bits [15:0] = count of descriptor indexes
rx_tid  input  ID_WIDTH  request type
rx_tdest  input  QUEUE_WIDTH  target queue
rx_tlast  input  1  passed through
tx_tvalid/tx_tready  output/input  1/1  forwarded request handshake
tx_tdata/tx_tid/tx_tdest/tx_tlast  output  as rx  registered copy of rx
monitor_tvalid, monitor_tready  input  1 each  passive tap of buffer read side
monitor_tdest  input  QUEUE_WIDTH  queue whose entry is read
error_clear  input  1  clears all sticky errors
level  output  NUM_QUEUES*CAPACITY_WIDTH  per-queue occupancy, queue q at [q*CAPACITY_WIDTH+:CAPACITY_WIDTH]
full  output  NUM_QUEUES  level[q]==CAPACITY
error_underflow, error_oversize  output  NUM_QUEUES each  sticky flags

Behaviour:
- Reset (async, any time, including mid-transfer): tx_tvalid=0; all levels=0; full=0; errors=0; registered monitor event cleared. tx data fields are not reset.
- Reservation add = (count + MAX_DESCRIPTOR_INDEXES-1) >> log2(MAX_DESCRIPTOR_INDEXES). Compute it in 17 bits, so there is no wrap. If count=0, add=0.
- A request is a read-ring request when rx_tid == REQUEST_READ_RING. Let q = rx_tdest.
- Read-ring request with oversize = add > CAPACITY: it is passed through with no reservation, and error_oversize[q] is set.
- Read-ring request that is not oversize: it is blocked when level[q] + add > CAPACITY (evaluated at CAPACITY_WIDTH+1 bits).
- rx_tready = tx_tready && !(rx_tvalid && blocked). Non-read-ring requests and requests to other queues are never blocked by this logic. Blocking is head-of-line: there is a single stream.
- tx pipeline is enable-style with 1-cycle latency. When tx_tready=1: tx_tvalid <= rx_tvalid && !blocked, and tx data fields <= rx fields. When tx_tready=0, tx holds its values.
- write = rx_tvalid && rx_tready && read-ring && !oversize. It adds add to level[rx_tdest].
- Monitor beats are registered: rd <= monitor_tvalid && monitor_tready, and rd_q <= monitor_tdest. The registered event subtracts 1 from level[rd_q] one cycle after the beat.
- Counter update per queue, each cycle: next = level + (write to q ? add : 0) - (rd to q ? 1 : 0). A simultaneous write and read on the same queue nets out. Reads and writes on different queues are independent.
- Underflow: rd to a queue with level 0 and no same-cycle write. The level stays 0 and error_underflow[q] is set.
- The admission check uses the current level. A pending rd makes the check conservative only and never causes overflow.
- level never exceeds CAPACITY by construction.
- Error flags: a set event takes priority over error_clear in the same cycle.

Test Plan:
1. Reset, then tx_tready=1 and rx idle -> tx_tvalid=0, rx_tready=1, all level=0, full=0, errors=0.
2. Read-ring request, q=1, count=5 -> add=2. rx accepted; level[1]=2 next cycle; tx_tvalid=1 for one cycle carrying the identical tdata/tid/tdest/tlast.
3. level[2]=15, read-ring request q=2 count=8 (add 2) -> rx_tready=0, tx_tvalid=0. A non-read-ring request queued behind it does not pass. Monitor beat on q=2 -> level[2]=14 two cycles after the beat. The request is then accepted, level[2]=16, full[2]=1.
4. level[0]=5: a read-ring request to q=0 with add=3 is accepted in the same cycle as a registered monitor read on q=0 -> level[0]=7.
5. Monitor beat on q=3 with level[3]=0 -> level[3] stays 0 and error_underflow[3]=1. The flag holds until error_clear is pulsed, then reads 0.
6. Read-ring request count=100 (add=25 > 16) on q=0 -> forwarded, level[0] unchanged, error_oversize[0]=1. A type-other request to a full queue is forwarded with 1-cycle latency. tx_tready=0 for 3 cycles mid-stream -> tx outputs hold and nothing is lost or duplicated.
